// File: rtl/banked_wait_memory_if.sv
// Request/response bus of the wait-state memory: one request set in, read data and status out.
interface banked_wait_memory_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  logic                  wp_fault;

  modport master (
    output req, we, address, data_in,
    input  data_out, ready, wp_fault
  );

  modport slave (
    input  req, we, address, data_in,
    output data_out, ready, wp_fault
  );
endinterface

// File: rtl/banked_wait_memory.sv
// Single-port memory with per-region wait states and a write-protected ROM region.
// Latency N+1 cycles from the Req edge to the one-cycle ready pulse; Req is ignored while waiting.
module banked_wait_memory #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE   = 16'hE000,
  parameter int unsigned           WAIT_RAM   = 0,
  parameter int unsigned           WAIT_ROM   = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_IMAGE [2**ADDR_WIDTH] = '{default: '0}
) (
  input logic                  clk_i,
  input logic                  rst_i,
  banked_wait_memory_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic                  fault_q;

  // The image is the only way ROM words ever get a value; the array is never reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = INIT_IMAGE;

  logic                  can_accept;
  logic [3:0]            req_wait;
  logic                  acc_en;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_dat;
  logic                  acc_rom;

  assign req_wait = (bus.address >= ROM_BASE) ? 4'(WAIT_ROM) : 4'(WAIT_RAM);
  assign acc_rom  = (acc_addr >= ROM_BASE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    acc_en     = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_dat    = wdat_q;
    can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // DONE accepts exactly like IDLE so back-to-back requests lose no cycle.
    if (can_accept && bus.req) begin
      we_d   = bus.we;
      addr_d = bus.address;
      wdat_d = bus.data_in;
      cnt_d  = req_wait;
      if (req_wait == 4'd0) begin
        acc_en   = 1'b1;
        acc_we   = bus.we;
        acc_addr = bus.address;
        acc_dat  = bus.data_in;
        state_d  = S_DONE;
      end else begin
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      if (acc_en) begin
        if (!acc_we) begin
          rdat_q <= mem_q[acc_addr];
        end else if (acc_rom) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_en && acc_we && !acc_rom) begin
      mem_q[acc_addr] <= acc_dat;
    end
  end

  assign bus.ready    = (state_q == S_DONE);
  assign bus.data_out = rdat_q;
  assign bus.wp_fault = fault_q;

endmodule
